// File: rtl/y86_pipe_reg_if.sv
// Bundle of the y86 pipeline-register control inputs, next-stage payload and
// registered outputs. The master drives the controls and payload; the slave (the register) drives the q_* side.
interface y86_pipe_reg_if #(
  parameter int DATA_W = 64,
  parameter int STAT_W = 4,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              bubble;
  logic              resume;
  logic              clr_cnt;
  logic [DATA_W-1:0] d_data;
  logic [STAT_W-1:0] d_stat;
  logic [DATA_W-1:0] q_data;
  logic [STAT_W-1:0] q_stat;
  logic              q_valid;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic              ctl_err;

  modport master (
    output stall, bubble, resume, clr_cnt, d_data, d_stat,
    input  q_data, q_stat, q_valid, halted, stall_cnt, ctl_err
  );

  modport slave (
    input  stall, bubble, resume, clr_cnt, d_data, d_stat,
    output q_data, q_stat, q_valid, halted, stall_cnt, ctl_err
  );
endinterface

// File: rtl/y86_pipe_reg.sv
// Y86 pipeline register with stall/bubble control, a halt state that is entered
// when a non-AOK status is loaded, a saturating stall counter and a sticky conflict flag.
module y86_pipe_reg #(
  parameter int                DATA_W   = 64,
  parameter int                STAT_W   = 4,
  parameter int                CNT_W    = 16,
  parameter logic [STAT_W-1:0] AOK_STAT = STAT_W'(1),
  parameter logic [STAT_W-1:0] BUB_STAT = '0,
  parameter logic [DATA_W-1:0] BUB_DATA = '0
) (
  input logic             clk,
  input logic             rst_n,
  y86_pipe_reg_if.slave   bus
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_halted;
  logic              w_hold;
  logic              w_load;
  logic              w_bub;
  logic [DATA_W-1:0] r_data;
  logic [STAT_W-1:0] r_stat;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: only a real load of a non-AOK status halts;
  // bubble-inserted status never does.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_load && (bus.d_stat != AOK_STAT)) w_state_nxt = ST_HALT;
      ST_HALT: if (bus.resume) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output decode of the state and the one-action-per-edge selection
  always_comb begin
    w_halted = (r_state == ST_HALT);
    w_hold   = w_halted | bus.stall;
    w_load   = ~w_hold & ~bus.bubble;
    w_bub    = ~w_hold & bus.bubble;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= BUB_DATA;
      r_stat  <= BUB_STAT;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_data  <= bus.d_data;
      r_stat  <= bus.d_stat;
      r_valid <= 1'b1;
    end else if (w_bub) begin
      r_data  <= BUB_DATA;
      r_stat  <= BUB_STAT;
      r_valid <= 1'b0;
    end
  end

  // Stall counter saturates at all-ones; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (bus.clr_cnt) begin
      r_cnt <= '0;
    end else if (bus.stall && !w_halted && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_err <= 1'b0;
    else if (!w_halted && bus.stall && bus.bubble) r_err <= 1'b1;
  end

  assign bus.q_data    = r_data;
  assign bus.q_stat    = r_stat;
  assign bus.q_valid   = r_valid;
  assign bus.halted    = w_halted;
  assign bus.stall_cnt = r_cnt;
  assign bus.ctl_err   = r_err;

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Bench for y86_pipe_reg: directed scenarios plus random traffic against a
// behavioural model, on a default instance and a narrow-counter (CNT_W=3) instance.
module tb_y86_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        bubble;
  logic        resume;
  logic        clr_cnt;
  logic [63:0] d_data;
  logic [3:0]  d_stat;

  int n_total;
  int n_bad;

  // Behavioural model state
  logic [63:0] m_data;
  logic [3:0]  m_stat;
  logic        m_valid;
  logic        m_halted;
  logic        m_err;
  int          m_cnt;
  int          m_cnt3;
  logic [63:0] exp_q[$];

  y86_pipe_reg_if #(.DATA_W(64), .STAT_W(4), .CNT_W(16)) bus_a ();
  y86_pipe_reg_if #(.DATA_W(64), .STAT_W(4), .CNT_W(3))  bus_b ();

  assign bus_a.stall   = stall;
  assign bus_a.bubble  = bubble;
  assign bus_a.resume  = resume;
  assign bus_a.clr_cnt = clr_cnt;
  assign bus_a.d_data  = d_data;
  assign bus_a.d_stat  = d_stat;
  assign bus_b.stall   = stall;
  assign bus_b.bubble  = bubble;
  assign bus_b.resume  = resume;
  assign bus_b.clr_cnt = clr_cnt;
  assign bus_b.d_data  = d_data;
  assign bus_b.d_stat  = d_stat;

  y86_pipe_reg #(.CNT_W(16)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  y86_pipe_reg #(.CNT_W(3))  u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data   = '0;
    m_stat   = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
    m_err    = 1'b0;
    m_cnt    = 0;
    m_cnt3   = 0;
    exp_q.delete();
  endtask

  // One clock edge of the intended behaviour, evaluated on the pre-edge state
  task automatic model_edge();
    logic h;
    h = m_halted;
    if (clr_cnt) begin
      m_cnt  = 0;
      m_cnt3 = 0;
    end else if (stall && !h) begin
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : 65535;
      m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : 7;
    end
    if (h) begin
      if (resume) m_halted = 1'b0;
    end else if (stall) begin
      if (bubble) m_err = 1'b1;
    end else if (bubble) begin
      m_data  = '0;
      m_stat  = '0;
      m_valid = 1'b0;
    end else begin
      m_data  = d_data;
      m_stat  = d_stat;
      m_valid = 1'b1;
      if (d_stat != 4'd1) m_halted = 1'b1;
    end
    exp_q.push_back(m_data);
  endtask

  task automatic check_all();
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'(exp_q.size()), 64'd1);
      e = m_data;
    end else begin
      e = exp_q.pop_front();
    end
    check("q_data",    bus_a.q_data, e);
    check("q_stat",    64'(bus_a.q_stat), 64'(m_stat));
    check("q_valid",   64'(bus_a.q_valid), 64'(m_valid));
    check("halted",    64'(bus_a.halted), 64'(m_halted));
    check("stall_cnt", 64'(bus_a.stall_cnt), 64'(m_cnt));
    check("ctl_err",   64'(bus_a.ctl_err), 64'(m_err));
    check("b_q_data",  bus_b.q_data, e);
    check("b_halted",  64'(bus_b.halted), 64'(m_halted));
    check("b_cnt",     64'(bus_b.stall_cnt), 64'(m_cnt3));
  endtask

  // Driver: inputs are set before calling; this advances one edge and checks.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input logic s, input logic b, input logic r, input logic c,
                        input logic [63:0] d, input logic [3:0] st);
    stall   = s;
    bubble  = b;
    resume  = r;
    clr_cnt = c;
    d_data  = d;
    d_stat  = st;
  endtask

  // Mid-cycle async reset; called at a negedge, returns at the next negedge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_data"},  bus_a.q_data, 64'd0);
    check({tag, "_stat"},  64'(bus_a.q_stat), 64'd0);
    check({tag, "_valid"}, 64'(bus_a.q_valid), 64'd0);
    check({tag, "_halt"},  64'(bus_a.halted), 64'd0);
    check({tag, "_cnt"},   64'(bus_a.stall_cnt), 64'd0);
    check({tag, "_err"},   64'(bus_a.ctl_err), 64'd0);
    check({tag, "_cnt3"},  64'(bus_b.stall_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    set_in(0, 0, 0, 0, 64'd0, 4'd1);
    model_reset();
    #12;
    check("rst_data",  bus_a.q_data, 64'd0);
    check("rst_valid", 64'(bus_a.q_valid), 64'd0);
    check("rst_halt",  64'(bus_a.halted), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load then stall
    set_in(0, 0, 0, 0, 64'h100, 4'd1);
    cycle();
    check("ls_load", bus_a.q_data, 64'h100);
    set_in(1, 0, 0, 0, 64'h200, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("ls_hold", bus_a.q_data, 64'h100);
    end
    check("ls_cnt", 64'(bus_a.stall_cnt), 64'd3);
    set_in(0, 0, 0, 0, 64'h200, 4'd1);
    cycle();
    check("ls_release", bus_a.q_data, 64'h200);

    // Bubble
    set_in(0, 0, 0, 0, 64'h40, 4'd1);
    cycle();
    set_in(0, 1, 0, 0, 64'h44, 4'd1);
    cycle();
    check("bub_data",  bus_a.q_data, 64'd0);
    check("bub_stat",  64'(bus_a.q_stat), 64'd0);
    check("bub_valid", 64'(bus_a.q_valid), 64'd0);
    set_in(0, 0, 0, 0, 64'h48, 4'd1);
    cycle();
    check("bub_reload", 64'(bus_a.q_valid), 64'd1);

    // Halt and resume
    set_in(0, 0, 0, 0, 64'h30, 4'd2);
    cycle();
    check("hlt_set", 64'(bus_a.halted), 64'd1);
    set_in(0, 0, 0, 0, 64'h38, 4'd1);
    cycle();
    set_in(0, 1, 0, 0, 64'h38, 4'd1);
    cycle();
    check("hlt_data", bus_a.q_data, 64'h30);
    check("hlt_stat", 64'(bus_a.q_stat), 64'd2);
    set_in(0, 0, 1, 0, 64'h38, 4'd1);
    cycle();
    check("res_halt", 64'(bus_a.halted), 64'd0);
    check("res_data", bus_a.q_data, 64'h30);
    set_in(0, 0, 0, 0, 64'h50, 4'd1);
    cycle();
    check("res_load", bus_a.q_data, 64'h50);

    // Conflict
    set_in(1, 1, 0, 0, 64'h58, 4'd1);
    cycle();
    check("cf_data", bus_a.q_data, 64'h50);
    check("cf_err",  64'(bus_a.ctl_err), 64'd1);
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 0, 64'($urandom), 4'd1);
      cycle();
    end
    check("cf_sticky", 64'(bus_a.ctl_err), 64'd1);

    // Counter saturation and clear on the narrow instance
    set_in(0, 0, 0, 1, 64'h60, 4'd1);
    cycle();
    set_in(1, 0, 0, 0, 64'h68, 4'd1);
    for (int i = 0; i < 10; i++) cycle();
    check("sat_cnt3", 64'(bus_b.stall_cnt), 64'd7);
    check("sat_cnt",  64'(bus_a.stall_cnt), 64'd10);
    set_in(1, 0, 0, 1, 64'h68, 4'd1);
    cycle();
    check("clr_cnt3", 64'(bus_b.stall_cnt), 64'd0);

    // Async reset while halted, cnt=5, ctl_err=1
    set_in(1, 0, 0, 0, 64'h70, 4'd1);
    for (int i = 0; i < 5; i++) cycle();
    set_in(0, 0, 0, 0, 64'h78, 4'd3);
    cycle();
    set_in(1, 1, 0, 0, 64'h80, 4'd1);
    cycle();
    check("pre_halt", 64'(bus_a.halted), 64'd1);
    check("pre_cnt",  64'(bus_a.stall_cnt), 64'd5);
    check("pre_err",  64'(bus_a.ctl_err), 64'd1);
    mid_reset("arst");
    set_in(0, 0, 0, 0, 64'h88, 4'd1);
    cycle();
    check("post_rst_load", bus_a.q_data, 64'h88);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] st;
      case ($urandom_range(0, 9))
        0:       st = 4'd0;
        1:       st = 4'($urandom_range(2, 15));
        default: st = 4'd1;
      endcase
      set_in(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0),
             {$urandom, $urandom}, st);
      if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
      else cycle();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
